ep2_packet_demux: RTL

- Upstream stage of the memory arbitrator's write side. Parses the EP2 (host-to-device) byte stream into packets and routes each payload to one of NUM_PORTS write FIFOs, selected by the port number in the packet header.
- Maintains a per-port cumulative byte count. The arbitrator consumes these counts as write_fifo_byte_counts.
- Single clock domain (clk). It drives the "in" side of the asynchronous write FIFOs.

---
 rtl/ep2_pkg.sv | 25 ++
 rtl/ep2_port_counter.sv | 23 ++
 rtl/ep2_packet_demux.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ep2_pkg.sv
// Shared definitions for the EP2 host-to-device packet demultiplexer:
// header field layout, default widths and the parser state encoding.
package ep2_pkg;

  localparam int PORT_LSB = 0;
  localparam int PORT_MSB = 1;
  localparam int PORT_WIDTH = PORT_MSB - PORT_LSB + 1;
  localparam logic [7:0] RSVD_MASK = 8'hFC;

  localparam int LEN_WIDTH_DEF = 16;
  localparam int COUNT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    LEN_HI  = 2'd1,
    LEN_LO  = 2'd2,
    PAYLOAD = 2'd3
  } ep2_state_e;

  // Saturating increment used for the header error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ep2_port_counter.sv
// Single-port cumulative byte counter; wraps modulo 2^WIDTH because the
// consumer works with modular deltas.
module ep2_port_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count one byte per enabled cycle; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ep2_packet_demux.sv
// Parses the EP2 byte stream into header/length/payload and steers payload
// bytes to the write FIFO selected by the header port field.
module ep2_packet_demux
  import ep2_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int LEN_WIDTH   = LEN_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_PORTS-1:0]           fifo_full,
  output logic [NUM_PORTS-1:0]           fifo_write,
  output logic [8*NUM_PORTS-1:0]         fifo_write_data,
  output logic [COUNT_WIDTH*NUM_PORTS-1:0] write_fifo_byte_counts,
  output logic [7:0]                     header_error_count,
  output logic                           busy
);

  ep2_state_e            state, state_next;
  logic [PORT_WIDTH-1:0] cur_port, cur_port_next;
  logic [LEN_WIDTH-1:0]  remaining, remaining_next;
  logic [7:0]            hdr_err, hdr_err_next;
  logic                  accept;

  // State and parser datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= HEADER;
      cur_port  <= '0;
      remaining <= '0;
      hdr_err   <= 8'd0;
    end else begin
      state     <= state_next;
      cur_port  <= cur_port_next;
      remaining <= remaining_next;
      hdr_err   <= hdr_err_next;
    end
  end

  // Handshake: only the currently addressed FIFO can stall the payload.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = 1'b0;
    end else if (state == PAYLOAD) begin
      in_ready = !fifo_full[cur_port];
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid && in_ready;

  // Next-state logic; every transition happens on an accepted byte.
  always_comb begin
    state_next     = state;
    cur_port_next  = cur_port;
    remaining_next = remaining;
    hdr_err_next   = hdr_err;
    if (accept) begin
      case (state)
        HEADER: begin
          if ((in_data & RSVD_MASK) != 8'h00) begin
            hdr_err_next = sat_inc8(hdr_err);
          end else begin
            cur_port_next = in_data[PORT_MSB:PORT_LSB];
            state_next    = LEN_HI;
          end
        end
        LEN_HI: begin
          remaining_next = LEN_WIDTH'({in_data, 8'h00});
          state_next     = LEN_LO;
        end
        LEN_LO: begin
          remaining_next = {remaining[LEN_WIDTH-1:8], in_data};
          if ({remaining[LEN_WIDTH-1:8], in_data} == '0) begin
            state_next = HEADER;
          end else begin
            state_next = PAYLOAD;
          end
        end
        PAYLOAD: begin
          remaining_next = remaining - LEN_WIDTH'(1);
          if (remaining == LEN_WIDTH'(1)) begin
            state_next = HEADER;
          end else begin
            state_next = PAYLOAD;
          end
        end
        default: begin
          state_next = HEADER;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // Zero-latency one-hot write strobe to the addressed FIFO.
  always_comb begin
    fifo_write = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (accept && (state == PAYLOAD) && (cur_port == PORT_WIDTH'(p))) begin
        fifo_write[p] = 1'b1;
      end else begin
        fifo_write[p] = 1'b0;
      end
    end
  end

  assign fifo_write_data    = reset ? {NUM_PORTS{in_data}} : '0;
  assign header_error_count = hdr_err;
  assign busy               = reset && (state != HEADER);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    ep2_port_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (fifo_write[p]),
      .count (write_fifo_byte_counts[COUNT_WIDTH*p +: COUNT_WIDTH])
    );
  end

endmodule
